lsu: RTL
========

Name: lsu

Overview:
- Load/store unit; sits downstream of the execute stage and consumes its valid/ready output handshake as the receiving end.
- Performs byte, halfword and word loads and stores over a single-outstanding request/response memory bus.
- Forwards non-memory results unchanged.
- Presents one result per instruction to writeback through a second valid/ready handshake.

Parameters:
- XLEN, 32, data and result width.
- AW, 32, memory address width.

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- l_valid_i  input  1  instruction valid from exu
- l_ready_o  output  1  lsu can accept from exu
- is_load_i  input  1  instruction is a load
- is_store_i  input  1  instruction is a store
- funct3_i  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- res_i  input  XLEN  exu result; effective address for loads/stores
- wdata_i  input  XLEN  store data (rs2)
- w_valid_o  output  1  result valid to wbu
- w_ready_i  input  1  wbu accepts
- res_o  output  XLEN  load data (extended) or forwarded exu result
- misalign_o  output  1  qualified by w_valid_o; access was misaligned
- mem_req_valid_o  output  1  bus request valid
- mem_req_ready_i  input  1  bus accepts request
- mem_req_addr_o  output  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_req_wen_o  output  1  1 = write
- mem_req_wdata_o  output  XLEN  lane-shifted store data
- mem_req_wmask_o  output  4  byte-lane mask
- mem_resp_valid_i  input  1  response valid (read data or write ack)
- mem_resp_data_i  input  XLEN  read word
- mem_resp_ready_o  output  1  lsu accepts response

Behaviour:
- Async reset: state IDLE; all outputs 0 except l_ready_o=1; captured registers cleared.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - l_ready_o=1. On l_valid_i, capture all inputs.
  - Non-memory op, or misaligned memory op → DONE.
  - Aligned memory op → REQ.
- Misalignment rule: h/hu with addr[0]=1, or w with addr[1:0]≠0. Misaligned ops never issue a bus request; res_o=0, misalign_o=1.
- REQ:
  - mem_req_valid_o=1; addr/wen/wdata/wmask held stable until accepted.
  - On mem_req_ready_i → RESP.
- RESP:
  - mem_resp_ready_o=1 (it is 0 in every other state).
  - On mem_resp_valid_i, register the extended load data (stores ignore the data) → DONE.
- DONE:
  - w_valid_o=1; res_o and misalign_o held until accepted.
  - On w_ready_i → IDLE.
- l_ready_o is 1 only in IDLE, so there is no overlap of accept and done.
- Latency from accept to w_valid_o:
  - non-memory op: 1 cycle;
  - memory op with zero-wait bus: 3 cycles.
- Store lanes: wdata replicated or shifted by 8*addr[1:0]. wmask: sb 0001<<addr[1:0], sh 0011<<addr[1:0], sw 1111.
- Load extraction: select byte/half by addr[1:0]. b/h sign-extend; bu/hu zero-extend; w passes the word.
- Stores return res_o=0.
- mem_resp_valid_i outside RESP is ignored.
- Reset mid-transaction aborts immediately. No replay; a late response after reset is ignored in IDLE.
- Unused funct3 values on memory ops are treated as w.

Decomposition:
- Shared defines/package: funct3 size encodings, FSM state encoding, XLEN/AW defaults, and the opinfo load/store bit indices already used by exu.
- One natural sub-module, lsu_align: purely combinational. Store shifts data and generates wmask; load extracts and extends the lane; also outputs the misalign flag.
- The FSM stays in lsu.

Test Plan:
- Non-memory: res_i=0x1234_5678, is_load_i=is_store_i=0, w_ready_i=1 → w_valid_o one cycle after accept, res_o=0x1234_5678, no bus activity.
- lb: addr 0x8000_0003, memory word 0x80FF_0000 → req addr 0x8000_0000, wen=0; res_o=0xFFFF_FF80. Same case as lbu → 0x0000_0080.
- sh: addr 0x8000_0002, wdata 0x0000_BEEF → wdata 0xBEEF_0000, wmask 1100; w_valid_o with res_o=0 after write ack.
- Backpressure: mem_req_ready_i low 3 cycles, then resp after 2 cycles, w_ready_i low 2 cycles → request fields stable throughout; l_ready_o=0 until DONE is accepted; exactly one result delivered.
- Misaligned lw at 0x8000_0002 → no mem_req_valid_o; w_valid_o next cycle with misalign_o=1, res_o=0.
- Reset asserted while in RESP, mem_resp_valid_i then pulsed → all outputs at reset values immediately; pulse ignored; next instruction accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared encodings for the load/store unit (sizes, FSM, opinfo bits)
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bit positions of the load/store flags inside the exu opinfo vector
  localparam int OPINFO_LOAD_BIT  = 0;
  localparam int OPINFO_STORE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unused funct3 codes fall through to word accesses
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    f3_unsigned = (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Lane steering for stores, lane extraction/extension for loads
// Rev    : 1.0
// ============================================================================
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic [XLEN-1:0] st_data_o,
  output logic [3:0]      wmask_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            misalign_o
);

  size_e           w_size;
  logic            w_uns;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_lane;

  always_comb begin
    w_size     = f3_size(funct3_i);
    w_uns      = f3_unsigned(funct3_i);
    w_shamt    = {off_i, 3'b000};
    w_lane     = ld_word_i >> w_shamt;
    st_data_o  = st_data_i << w_shamt;
    wmask_o    = 4'b1111;
    ld_data_o  = ld_word_i;
    misalign_o = 1'b0;
    case (w_size)
      SZ_B: begin
        wmask_o   = 4'b0001 << off_i;
        ld_data_o = w_uns ? {{(XLEN-8){1'b0}}, w_lane[7:0]}
                          : {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      end
      SZ_H: begin
        misalign_o = off_i[0];
        wmask_o    = 4'b0011 << off_i;
        ld_data_o  = w_uns ? {{(XLEN-16){1'b0}}, w_lane[15:0]}
                           : {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        misalign_o = |off_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module : lsu
// Brief  : Load/store unit, single-outstanding bus, valid/ready on both sides
// Rev    : 1.0
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            l_valid_i,
  output logic            l_ready_o,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] res_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            misalign_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [AW-1:0]   mem_req_addr_o,
  output logic            mem_req_wen_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  output logic [3:0]      mem_req_wmask_o,
  input  logic            mem_resp_valid_i,
  input  logic [XLEN-1:0] mem_resp_data_i,
  output logic            mem_resp_ready_o
);

  state_e          state_q, state_d;
  logic            ld_q, st_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] res_q, res_d;
  logic            mis_q, mis_d;

  logic            w_idle;
  logic            w_accept;
  logic [2:0]      w_f3;
  logic [1:0]      w_off;
  logic [XLEN-1:0] w_st_data;
  logic [3:0]      w_wmask;
  logic [XLEN-1:0] w_ld_data;
  logic            w_mis;

  // In IDLE the aligner looks at the incoming op so misalignment is known at accept
  assign w_idle   = (state_q == IDLE);
  assign w_accept = w_idle & l_valid_i;
  assign w_f3     = w_idle ? funct3_i   : f3_q;
  assign w_off    = w_idle ? res_i[1:0] : addr_q[1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i   (w_f3),
    .off_i      (w_off),
    .st_data_i  (wdata_q),
    .ld_word_i  (mem_resp_data_i),
    .st_data_o  (w_st_data),
    .wmask_o    (w_wmask),
    .ld_data_o  (w_ld_data),
    .misalign_o (w_mis)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
      if (w_accept) begin
        ld_q    <= is_load_i;
        st_q    <= is_store_i;
        f3_q    <= funct3_i;
        addr_q  <= res_i[AW-1:0];
        wdata_q <= wdata_i;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    res_d            = res_q;
    mis_d            = mis_q;
    l_ready_o        = 1'b0;
    w_valid_o        = 1'b0;
    res_o            = '0;
    misalign_o       = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_req_addr_o   = '0;
    mem_req_wen_o    = 1'b0;
    mem_req_wdata_o  = '0;
    mem_req_wmask_o  = 4'b0000;
    mem_resp_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        l_ready_o = 1'b1;
        if (l_valid_i) begin
          if (!(is_load_i || is_store_i)) begin
            res_d   = res_i;
            mis_d   = 1'b0;
            state_d = DONE;
          end else if (w_mis) begin
            res_d   = '0;
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            res_d   = '0;
            mis_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {addr_q[AW-1:2], 2'b00};
        mem_req_wen_o   = st_q;
        mem_req_wdata_o = st_q ? w_st_data : '0;
        mem_req_wmask_o = w_wmask;
        if (mem_req_ready_i) state_d = RESP;
      end
      RESP: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          res_d   = ld_q ? w_ld_data : '0;
          state_d = DONE;
        end
      end
      default: begin
        w_valid_o  = 1'b1;
        res_o      = res_q;
        misalign_o = mis_q;
        if (w_ready_i) state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
